dmem_responder: RTL

- Memory-side responder for the CPU data port: accepts load/store requests (chip select, read/write strobes, byte address, write data) and returns read data plus an acknowledge.
- Owns a synchronous-read single-port block RAM.
- Adds byte/halfword access with sign/zero extension, read-modify-write for sub-word stores, and alignment checking.
- Replaces the direct distributed-RAM hookup beside flow_cpu; flow_cpu stalls on dm_stall.

---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_sram_sp.sv | 26 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM states and the lane helpers used for sub-word loads and stores.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_RMW  = 2'b10,
    ST_ACK  = 2'b11
  } state_t;

  // A request is accepted only if it is exactly one of load/store, has a
  // defined size, and is naturally aligned for that size.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [1:0] lo, input logic [1:0] size);
    logic ok;
    ok = rd ^ wr;
    case (size)
      SZ_BYTE: ;
      SZ_HALF: if (lo[0]) ok = 1'b0;
      SZ_WORD: if (lo != 2'b00) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Picks the addressed byte/half out of a little-endian word, right-aligns
  // it and sign- or zero-extends it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0] lane,
                                               input logic [1:0] size,
                                               input logic sign_ext);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: res = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replaces the addressed lanes of the old word with right-aligned store
  // data, leaving every other byte of the word untouched.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0] lane,
                                             input logic [1:0] size);
    logic [31:0] mask;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {lane, 3'b000};
    return (old_word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bus between the core (master) and the memory responder (slave).
interface dmem_responder_if;

  logic        DM_CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        ack;
  logic        addr_err;
  logic        dm_stall;

  modport master (
    output DM_CS, DM_R, DM_W, addr, wdata, size, sign_ext,
    input  rdata, ack, addr_err, dm_stall
  );

  modport slave (
    input  DM_CS, DM_R, DM_W, addr, wdata, size, sign_ext,
    output rdata, ack, addr_err, dm_stall
  );

endinterface

// File: rtl/dmem_sram_sp.sv
// Single-port block RAM with a registered read port; a write returns the
// newly written word on the read port (write-first).
module dmem_sram_sp #(
  parameter int    ADDR_W    = 11,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // One access per cycle: write (with write-through to the read port) or read.
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: decodes load/store requests,
// checks alignment, performs sub-word extraction and read-modify-write
// stores on a synchronous-read RAM, and returns a one-cycle ack.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 11,
  parameter string INIT_FILE = ""
) (
  input  logic clk_in,
  input  logic reset,
  dmem_responder_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ack_q;
  logic              err_q;

  logic              legal;
  logic              word_store;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic              unused_addr_hi;

  assign legal      = req_legal(bus.DM_R, bus.DM_W, bus.addr[1:0], bus.size);
  assign word_store = (state == ST_IDLE) && bus.DM_CS && legal && bus.DM_W
                      && (bus.size == SZ_WORD);

  // The RAM port belongs to the request address except while a sub-word
  // store writes its merged word back; reset blocks any write at that edge.
  assign ram_we    = ~reset & (word_store | (state == ST_RMW));
  assign ram_addr  = (state == ST_RMW) ? idx_q : bus.addr[ADDR_W+1:2];
  assign ram_wdata = (state == ST_RMW) ? lane_merge(ram_q, wdata_q, lane_q, size_q)
                                       : bus.wdata;

  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  dmem_sram_sp #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk_in (clk_in),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (ram_wdata),
    .rdata  (ram_q)
  );

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.addr_err = err_q;
  assign bus.dm_stall = bus.DM_CS & ~ack_q;

  // Latch the request attributes when a request is seen in IDLE so the
  // later RD/RMW cycle does not depend on the CPU holding them.
  always_ff @(posedge clk_in) begin
    if (state == ST_IDLE && bus.DM_CS) begin
      idx_q   <= bus.addr[ADDR_W+1:2];
      lane_q  <= bus.addr[1:0];
      size_q  <= bus.size;
      sext_q  <= bus.sign_ext;
      wdata_q <= bus.wdata;
    end
  end

  // Request FSM: every accepted request ends in exactly one ACK cycle, and
  // ACK always returns to IDLE so a held DM_CS is not re-taken that cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.DM_CS) begin
            if (!legal) begin
              state <= ST_ACK;
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else if (bus.DM_R) begin
              state <= ST_RD;
            end else if (bus.size == SZ_WORD) begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end else begin
              state <= ST_RMW;
            end
          end
        end
        ST_RD: begin
          rdata_q <= lane_extract(ram_q, lane_q, size_q, sext_q);
          ack_q   <= 1'b1;
          state   <= ST_ACK;
        end
        ST_RMW: begin
          ack_q <= 1'b1;
          state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
